// File: rtl/stdp_pkg.sv
// Shared definitions for the STDP pair scheduler.
//   stdp_state_e : FSM state encoding (also exported on state_dbg)
//   DW_W         : width of the signed weight step
//   clamp_int    : saturate an integer into [lo, hi]
package stdp_pkg;

  localparam int unsigned DW_W = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWait    = 3'd1,
    StUpdate  = 3'd2,
    StRefract = 3'd3
  } stdp_state_e;

  function automatic int clamp_int(input int value, input int lo, input int hi);
    if (value < lo) begin
      return lo;
    end else if (value > hi) begin
      return hi;
    end
    return value;
  endfunction

endpackage

// File: rtl/stdp_dw_calc.sv
// Combinational STDP step calculator.
//   dt        in  CNT_W  inter-spike interval in cycles
//   pre_first in  1      1: pre led post (LTP, positive step); 0: post led pre (LTD)
//   upd_dw    out DW_W   signed step, +/- (A >> min(dt >> TAU_SHIFT, 7))
module stdp_dw_calc
  import stdp_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned A_PLUS    = 8,
  parameter int unsigned A_MINUS   = 6,
  parameter int unsigned TAU_SHIFT = 2
) (
  input  logic [CNT_W-1:0] dt,
  input  logic             pre_first,
  output logic [DW_W-1:0]  upd_dw
);

  logic [CNT_W-1:0] tau_idx;
  logic [2:0]       shamt;
  logic [DW_W-1:0]  amp;
  logic [DW_W-1:0]  mag;

  always_comb begin
    tau_idx = dt >> TAU_SHIFT;
    // Beyond seven halvings every amplitude <= 127 is already zero.
    shamt   = (tau_idx > CNT_W'(7)) ? 3'd7 : tau_idx[2:0];
    amp     = pre_first ? DW_W'(A_PLUS) : DW_W'(A_MINUS);
    mag     = amp >> shamt;
    upd_dw  = pre_first ? mag : (~mag + DW_W'(1));
  end

endmodule

// File: rtl/stdp_pair_scheduler.sv
// STDP pair scheduler: pairs pre/post spikes, measures their interval, offers a signed
// weight step on a valid/ready handshake and owns the saturating synaptic weight.
//   clk, rst_n   clock, asynchronous active-low reset
//   learn_en     enables pairing; low aborts a pending pairing window
//   pre_spike    presynaptic spike pulse
//   post_spike   postsynaptic spike pulse
//   upd_valid    step offered (held until accepted)
//   upd_ready    consumer accept
//   upd_dw       signed step, stable while upd_valid
//   dt_out       interval of the last accepted pair
//   weight       current synaptic weight
//   busy         FSM not idle
//   state_dbg    encoded FSM state
module stdp_pair_scheduler
  import stdp_pkg::*;
#(
  parameter int unsigned W_W       = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned WINDOW    = 16,
  parameter int unsigned A_PLUS    = 8,
  parameter int unsigned A_MINUS   = 6,
  parameter int unsigned TAU_SHIFT = 2,
  parameter int unsigned REFRACT   = 4,
  parameter int unsigned W_INIT    = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             learn_en,
  input  logic             pre_spike,
  input  logic             post_spike,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [DW_W-1:0]  upd_dw,
  output logic [CNT_W-1:0] dt_out,
  output logic [W_W-1:0]   weight,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam int unsigned REF_W = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam int unsigned EXT_W = W_W + 2 - DW_W;
  localparam int          W_MAX = (1 << W_W) - 1;

  stdp_state_e      state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [REF_W-1:0] ref_q, ref_d;
  logic             pre_first_q, pre_first_d;
  logic             upd_valid_q, upd_valid_d;
  logic [DW_W-1:0]  upd_dw_q, upd_dw_d;
  logic [CNT_W-1:0] dt_out_q, dt_out_d;
  logic [W_W-1:0]   weight_q, weight_d;

  logic [CNT_W-1:0]     dt_cur;
  logic [DW_W-1:0]      dw_calc;
  logic                 partner_spike;
  logic                 same_spike;
  logic signed [W_W+1:0] sum_w;

  // counter_q is 0 in the first WAIT cycle, so the elapsed interval is one more.
  assign dt_cur        = counter_q + CNT_W'(1);
  assign partner_spike = pre_first_q ? post_spike : pre_spike;
  assign same_spike    = pre_first_q ? pre_spike : post_spike;
  assign sum_w         = $signed({2'b00, weight_q})
                       + $signed({{EXT_W{upd_dw_q[DW_W-1]}}, upd_dw_q});

  stdp_dw_calc #(
    .CNT_W    (CNT_W),
    .A_PLUS   (A_PLUS),
    .A_MINUS  (A_MINUS),
    .TAU_SHIFT(TAU_SHIFT)
  ) u_dw_calc (
    .dt       (dt_cur),
    .pre_first(pre_first_q),
    .upd_dw   (dw_calc)
  );

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    ref_d       = ref_q;
    pre_first_d = pre_first_q;
    upd_valid_d = upd_valid_q;
    upd_dw_d    = upd_dw_q;
    dt_out_d    = dt_out_q;
    weight_d    = weight_q;

    unique case (state_q)
      StIdle: begin
        if (learn_en) begin
          if (pre_spike && post_spike) begin
            state_d = StRefract;
            ref_d   = REF_W'(REFRACT - 1);
          end else if (pre_spike || post_spike) begin
            state_d     = StWait;
            pre_first_d = pre_spike;
            counter_d   = '0;
          end
        end
      end
      StWait: begin
        if (!learn_en) begin
          state_d = StIdle;
        end else if (partner_spike) begin
          // Partner beats a simultaneous same-side restart.
          state_d     = StUpdate;
          upd_valid_d = 1'b1;
          upd_dw_d    = dw_calc;
          dt_out_d    = dt_cur;
        end else if (same_spike) begin
          counter_d = '0;
        end else if (dt_cur == CNT_W'(WINDOW - 1)) begin
          state_d = StIdle;
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      StUpdate: begin
        if (upd_ready) begin
          weight_d    = W_W'(clamp_int(int'(sum_w), 0, W_MAX));
          upd_valid_d = 1'b0;
          state_d     = StRefract;
          ref_d       = REF_W'(REFRACT - 1);
        end
      end
      StRefract: begin
        if (ref_q == '0) begin
          state_d = StIdle;
        end else begin
          ref_d = ref_q - REF_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      counter_q   <= '0;
      ref_q       <= '0;
      pre_first_q <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_dw_q    <= '0;
      dt_out_q    <= '0;
      weight_q    <= W_W'(W_INIT);
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      ref_q       <= ref_d;
      pre_first_q <= pre_first_d;
      upd_valid_q <= upd_valid_d;
      upd_dw_q    <= upd_dw_d;
      dt_out_q    <= dt_out_d;
      weight_q    <= weight_d;
    end
  end

  assign upd_valid = upd_valid_q;
  assign upd_dw    = upd_dw_q;
  assign dt_out    = dt_out_q;
  assign weight    = weight_q;
  assign busy      = (state_q != StIdle);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_stdp_pair_scheduler.sv
module tb_stdp_pair_scheduler;

  localparam int WINDOW  = 16;
  localparam int A_PLUS  = 8;
  localparam int A_MINUS = 6;
  localparam int REFRACT = 4;
  localparam int W_INIT  = 128;
  localparam int W_MAX   = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       learn_en = 1'b0;
  logic       pre_spike = 1'b0;
  logic       post_spike = 1'b0;
  logic       upd_ready = 1'b0;
  logic       upd_valid;
  logic [7:0] upd_dw;
  logic [7:0] dt_out;
  logic [7:0] weight;
  logic       busy;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Event-level reference model: timestamps instead of counters.
  bit m_pairing;
  bit m_pre_first;
  int m_t_first;
  bit m_pending;
  int m_dw;
  int m_dt;
  int m_ref_end;
  int m_weight;

  always #5 clk = ~clk;

  stdp_pair_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .learn_en  (learn_en),
    .pre_spike (pre_spike),
    .post_spike(post_spike),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_dw    (upd_dw),
    .dt_out    (dt_out),
    .weight    (weight),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pairing   = 0;
    m_pre_first = 0;
    m_t_first   = 0;
    m_pending   = 0;
    m_dw        = 0;
    m_dt        = 0;
    m_ref_end   = -100;
    m_weight    = W_INIT;
  endtask

  task automatic model_edge(input bit p, input bit q, input bit en, input bit rdy);
    bit in_ref;
    int elapsed;
    int sh;
    int amp;
    in_ref = (cyc <= m_ref_end);
    if (m_pending) begin
      if (rdy) begin
        m_weight = m_weight + m_dw;
        if (m_weight > W_MAX) m_weight = W_MAX;
        if (m_weight < 0) m_weight = 0;
        m_pending = 0;
        m_ref_end = cyc + REFRACT;
      end
    end else if (in_ref) begin
      // refractory: spikes ignored
    end else if (m_pairing) begin
      elapsed = cyc - m_t_first;
      if (!en) begin
        m_pairing = 0;
      end else if (m_pre_first ? q : p) begin
        sh = elapsed / 4;
        if (sh > 7) sh = 7;
        amp = m_pre_first ? A_PLUS : A_MINUS;
        m_dt = elapsed;
        m_dw = m_pre_first ? (amp / (1 << sh)) : -(amp / (1 << sh));
        m_pending = 1;
        m_pairing = 0;
      end else if (m_pre_first ? p : q) begin
        m_t_first = cyc;
      end else if (elapsed == WINDOW - 1) begin
        m_pairing = 0;
      end
    end else if (en) begin
      if (p && q) begin
        m_ref_end = cyc + REFRACT;
      end else if (p || q) begin
        m_pairing   = 1;
        m_t_first   = cyc;
        m_pre_first = p;
      end
    end
  endtask

  function automatic int model_state();
    if (m_pending) return 2;
    if (m_pairing) return 1;
    if (cyc < m_ref_end) return 3;
    return 0;
  endfunction

  task automatic check_outputs(input string where);
    chk({where, ":state_dbg"}, int'(state_dbg), model_state());
    chk({where, ":busy"}, int'(busy), (model_state() != 0) ? 1 : 0);
    chk({where, ":upd_valid"}, int'(upd_valid), int'(m_pending));
    chk({where, ":upd_dw"}, int'(upd_dw), m_dw & 255);
    chk({where, ":dt_out"}, int'(dt_out), m_dt);
    chk({where, ":weight"}, int'(weight), m_weight);
  endtask

  task automatic step(input bit p, input bit q, input bit en, input bit rdy, input string where);
    pre_spike  = p;
    post_spike = q;
    learn_en   = en;
    upd_ready  = rdy;
    @(posedge clk);
    cyc++;
    model_edge(p, q, en, rdy);
    #1;
    check_outputs(where);
  endtask

  task automatic do_reset(input string where);
    rst_n = 1'b0;
    pre_spike = 1'b0;
    post_spike = 1'b0;
    #1;
    model_reset();
    check_outputs(where);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    // 1: pre then post three cycles later -> dt 3, +8.
    step(1, 0, 1, 1, "t1");
    step(0, 0, 1, 1, "t1");
    step(0, 0, 1, 1, "t1");
    step(0, 1, 1, 1, "t1");
    chk("t1_valid", int'(upd_valid), 1);
    chk("t1_dt", int'(dt_out), 3);
    chk("t1_dw", int'(upd_dw), 8);
    step(0, 0, 1, 1, "t1");
    chk("t1_weight", int'(weight), 136);
    repeat (5) step(0, 0, 1, 1, "t1");

    // 2: post then pre nine cycles later -> dt 9, -1.
    do_reset("t2rst");
    step(0, 1, 1, 1, "t2");
    repeat (8) step(0, 0, 1, 1, "t2");
    step(1, 0, 1, 1, "t2");
    chk("t2_dt", int'(dt_out), 9);
    chk("t2_dw", int'(upd_dw), 8'hFF);
    step(0, 0, 1, 1, "t2");
    chk("t2_weight", int'(weight), 127);
    repeat (5) step(0, 0, 1, 1, "t2");

    // 3: lone pre times out after the window.
    do_reset("t3rst");
    step(1, 0, 1, 1, "t3");
    repeat (20) step(0, 0, 1, 1, "t3");
    chk("t3_state", int'(state_dbg), 0);
    chk("t3_weight", int'(weight), 128);

    // 4: sixteen LTP pairs saturate at 255.
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 1, 1, "t4");
      step(0, 1, 1, 1, "t4");
      chk("t4_dw", int'(upd_dw), 8);
      repeat (6) step(0, 0, 1, 1, "t4");
    end
    chk("t4_weight", int'(weight), 255);

    // 5: coincidence -> four refractory cycles, no update.
    do_reset("t5rst");
    step(1, 1, 1, 1, "t5");
    for (int i = 0; i < 3; i++) begin
      chk("t5_refract", int'(state_dbg), 3);
      step(0, 0, 1, 1, "t5");
    end
    chk("t5_refract_last", int'(state_dbg), 3);
    step(0, 0, 1, 1, "t5");
    chk("t5_idle", int'(state_dbg), 0);
    chk("t5_novalid", int'(upd_valid), 0);

    // 6: stalled consumer with spikes injected, then reset mid-hold.
    step(1, 0, 1, 0, "t6");
    step(0, 0, 1, 0, "t6");
    step(0, 1, 1, 0, "t6");
    for (int i = 0; i < 5; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
           "t6hold");
      chk("t6_dt", int'(dt_out), 2);
      chk("t6_dw", int'(upd_dw), 8);
      chk("t6_valid", int'(upd_valid), 1);
    end
    do_reset("t6rst");
    chk("t6_rst_valid", int'(upd_valid), 0);
    chk("t6_rst_weight", int'(weight), 128);
    chk("t6_rst_state", int'(state_dbg), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) < 12), 1'($urandom_range(0, 99) < 12),
           1'($urandom_range(0, 99) < 95), 1'($urandom_range(0, 99) < 70), "rand");
      if ($urandom_range(0, 999) == 0) do_reset("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
